// File: rtl/decode_3_8_scan_if.sv
// Bus bundle for decode_3_8_scan: control inputs, index handshake and decoded outputs.
// Revision: 1.0
`default_nettype none

interface decode_3_8_scan_if #(
  parameter int N_SEL = 3
);
  localparam int OUT_W = 1 << N_SEL;

  logic             i_en;
  logic             i_hl;
  logic             i_mode;
  logic [N_SEL-1:0] i_in;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [OUT_W-1:0] o_out;
  logic [N_SEL-1:0] o_idx;
  logic             o_out_valid;
  logic             o_wrap;

  modport master (
    output i_en, i_hl, i_mode, i_in, i_in_valid,
    input  o_in_ready, o_out, o_idx, o_out_valid, o_wrap
  );

  modport slave (
    input  i_en, i_hl, i_mode, i_in, i_in_valid,
    output o_in_ready, o_out, o_idx, o_out_valid, o_wrap
  );
endinterface

`default_nettype wire

// File: rtl/decode_3_8_scan.sv
//==============================================================================
// Module      : decode_3_8_scan
// Description : Registered binary-to-one-hot decoder with a handshaken direct
//               mode and a free-running scan mode (DIV cycles per line).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module decode_3_8_scan #(
  parameter int N_SEL = 3,
  parameter int DIV   = 4
) (
  input  wire               clk,
  input  wire               rst,
  decode_3_8_scan_if.slave  bus
);

  localparam int               OUT_W     = 1 << N_SEL;
  localparam logic [1:0]       S_OFF     = 2'd0;
  localparam logic [1:0]       S_DIRECT  = 2'd1;
  localparam logic [1:0]       S_SCAN    = 2'd2;
  localparam logic [15:0]      C_DIV_M1  = 16'(DIV - 1);
  localparam logic [N_SEL-1:0] C_IDX_MAX = '1;
  localparam logic [OUT_W-1:0] C_ONE     = OUT_W'(1);

  generate
    if (DIV < 1 || DIV > 65535) begin : g_div_check
      $error("decode_3_8_scan: DIV out of range 1..65535");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [OUT_W-1:0] r_raw;
  logic [N_SEL-1:0] r_idx;
  logic [15:0]      r_cnt;
  logic             r_out_valid;
  logic             r_wrap;

  logic [1:0]       w_next_state;
  logic             w_in_ready;
  logic             w_accept;
  logic [N_SEL-1:0] w_idx_inc;

  always_comb begin
    w_next_state = S_OFF;
    if (bus.i_en) begin
      w_next_state = bus.i_mode ? S_SCAN : S_DIRECT;
    end
  end

  // Ready only while already in direct mode and staying there, so a mode or
  // enable change in the same cycle as IN_VALID can never transfer.
  assign w_in_ready = (r_state == S_DIRECT) && bus.i_en && !bus.i_mode;
  assign w_accept   = bus.i_in_valid && w_in_ready;
  assign w_idx_inc  = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_raw       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (w_next_state)
        S_DIRECT: begin
          r_cnt  <= '0;
          r_wrap <= 1'b0;
          if (w_accept) begin
            r_raw       <= C_ONE << bus.i_in;
            r_idx       <= bus.i_in;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        S_SCAN: begin
          r_out_valid <= 1'b0;
          if (r_state != S_SCAN) begin
            r_idx  <= '0;
            r_raw  <= C_ONE;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
          end else if (r_cnt == C_DIV_M1) begin
            r_cnt  <= '0;
            r_idx  <= w_idx_inc;
            r_raw  <= C_ONE << w_idx_inc;
            r_wrap <= (r_idx == C_IDX_MAX);
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_wrap <= 1'b0;
          end
        end
        default: begin
          r_raw       <= '0;
          r_idx       <= '0;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_wrap      <= 1'b0;
        end
      endcase
    end
  end

  // Polarity is applied after the register so HL acts in the same cycle.
  assign bus.o_out       = bus.i_hl ? r_raw : ~r_raw;
  assign bus.o_idx       = r_idx;
  assign bus.o_in_ready  = w_in_ready;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decode_3_8_scan.sv
// Directed self-checking bench for decode_3_8_scan (N_SEL=3, DIV=4).
// Revision: 1.0
`default_nettype none

module tb_decode_3_8_scan;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decode_3_8_scan_if #(.N_SEL(3)) bus ();

  decode_3_8_scan #(.N_SEL(3), .DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoded lines must be zero or exactly one-hot at all times.
  always @(negedge clk) begin
    logic [7:0] dec;
    dec = bus.i_hl ? bus.o_out : ~bus.o_out;
    n_checks++;
    if (!$onehot0(dec)) begin
      n_fail++;
      $display("FAIL onehot: raw=%h not zero/one-hot", dec);
    end
  end

  task automatic test_reset();
    rst = 1'b1; bus.i_hl = 1'b1; bus.i_en = 1'b0; bus.i_mode = 1'b0;
    bus.i_in = '0; bus.i_in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (bus.o_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", bus.o_out); end
    n_checks++; if (bus.o_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus.o_idx); end
    n_checks++; if (bus.o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.o_in_ready); end
    n_checks++; if (bus.o_out_valid !== 1'b0 || bus.o_wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: ov=%b wrap=%b want 0 0", bus.o_out_valid, bus.o_wrap);
    end
    bus.i_hl = 1'b0; #1;
    n_checks++; if (bus.o_out !== 8'hFF) begin n_fail++; $display("FAIL reset_hl0: got %h want FF", bus.o_out); end
    bus.i_hl = 1'b1; #1;
  endtask

  task automatic test_direct();
    rst = 1'b0; bus.i_en = 1'b1; bus.i_mode = 1'b0;
    tick();
    n_checks++; if (bus.o_in_ready !== 1'b1) begin n_fail++; $display("FAIL direct_ready: got %b want 1", bus.o_in_ready); end
    n_checks++; if (bus.o_out !== 8'h00) begin n_fail++; $display("FAIL direct_entry: got %h want 00", bus.o_out); end
    bus.i_in = 3'd5; bus.i_in_valid = 1'b1;
    tick();
    bus.i_in_valid = 1'b0;
    n_checks++; if (bus.o_out !== 8'h20) begin n_fail++; $display("FAIL direct_out: got %h want 20", bus.o_out); end
    n_checks++; if (bus.o_idx !== 3'd5) begin n_fail++; $display("FAIL direct_idx: got %0d want 5", bus.o_idx); end
    n_checks++; if (bus.o_out_valid !== 1'b1) begin n_fail++; $display("FAIL direct_ov: got %b want 1", bus.o_out_valid); end
    tick();
    n_checks++; if (bus.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL direct_ov_drop: got %b want 0", bus.o_out_valid); end
    n_checks++; if (bus.o_out !== 8'h20) begin n_fail++; $display("FAIL direct_hold: got %h want 20", bus.o_out); end
    bus.i_hl = 1'b0; #1;
    n_checks++; if (bus.o_out !== 8'hDF) begin n_fail++; $display("FAIL direct_hl0: got %h want DF", bus.o_out); end
    bus.i_hl = 1'b1; #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ins  [3] = '{3'd0, 3'd3, 3'd7};
    logic [7:0] outs [3] = '{8'h01, 8'h08, 8'h80};
    for (int i = 0; i < 3; i++) begin
      bus.i_in = ins[i]; bus.i_in_valid = 1'b1;
      tick();
      n_checks++; if (bus.o_out !== outs[i] || bus.o_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d: out=%h ov=%b want %h 1", i, bus.o_out, bus.o_out_valid, outs[i]);
      end
    end
    bus.i_in_valid = 1'b0;
    tick();
    n_checks++; if (bus.o_out !== 8'h80 || bus.o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: out=%h ov=%b want 80 0", bus.o_out, bus.o_out_valid);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp;
    bus.i_mode = 1'b1; bus.i_in = 3'd2; bus.i_in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp = 8'h01 << ((k / 4) % 8);
      n_checks++; if (bus.o_out !== exp) begin n_fail++; $display("FAIL scan_out_%0d: got %h want %h", k, bus.o_out, exp); end
      n_checks++; if (bus.o_wrap !== (k == 32)) begin n_fail++; $display("FAIL scan_wrap_%0d: got %b want %b", k, bus.o_wrap, (k == 32)); end
      n_checks++; if (bus.o_in_ready !== 1'b0 || bus.o_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL scan_hs_%0d: ready=%b ov=%b want 0 0", k, bus.o_in_ready, bus.o_out_valid);
      end
    end
    bus.i_in_valid = 1'b0;
  endtask

  task automatic test_disable_mid_scan();
    logic [7:0] exp;
    bus.i_en = 1'b0; tick();
    bus.i_en = 1'b1; tick();
    for (int k = 0; k < 16; k++) tick();
    n_checks++; if (bus.o_out !== 8'h10) begin n_fail++; $display("FAIL dis_pre: got %h want 10", bus.o_out); end
    bus.i_en = 1'b0; tick();
    n_checks++; if (bus.o_out !== 8'h00 || bus.o_idx !== 3'd0) begin
      n_fail++; $display("FAIL dis_off: out=%h idx=%0d want 00 0", bus.o_out, bus.o_idx);
    end
    bus.i_hl = 1'b0; #1;
    n_checks++; if (bus.o_out !== 8'hFF) begin n_fail++; $display("FAIL dis_hl0: got %h want FF", bus.o_out); end
    bus.i_hl = 1'b1;
    bus.i_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp = (k < 4) ? 8'h01 : 8'h02;
      n_checks++; if (bus.o_out !== exp) begin n_fail++; $display("FAIL dis_restart_%0d: got %h want %h", k, bus.o_out, exp); end
    end
  endtask

  task automatic test_mode_switch();
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (bus.o_out !== 8'h04) begin n_fail++; $display("FAIL ms_pre: got %h want 04", bus.o_out); end
    bus.i_mode = 1'b0; tick();
    n_checks++; if (bus.o_out !== 8'h04 || bus.o_idx !== 3'd2) begin
      n_fail++; $display("FAIL ms_hold: out=%h idx=%0d want 04 2", bus.o_out, bus.o_idx);
    end
    n_checks++; if (bus.o_in_ready !== 1'b1) begin n_fail++; $display("FAIL ms_ready: got %b want 1", bus.o_in_ready); end
    bus.i_in = 3'd6; bus.i_in_valid = 1'b1; tick();
    bus.i_in_valid = 1'b0;
    n_checks++; if (bus.o_out !== 8'h40 || bus.o_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ms_xfer: out=%h ov=%b want 40 1", bus.o_out, bus.o_out_valid);
    end
    // Mode change coincident with IN_VALID: no transfer, scan restarts.
    bus.i_mode = 1'b1; bus.i_in = 3'd3; bus.i_in_valid = 1'b1; #1;
    n_checks++; if (bus.o_in_ready !== 1'b0) begin n_fail++; $display("FAIL ms_race_ready: got %b want 0", bus.o_in_ready); end
    tick();
    bus.i_in_valid = 1'b0;
    n_checks++; if (bus.o_out !== 8'h01 || bus.o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ms_race: out=%h ov=%b want 01 0", bus.o_out, bus.o_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (bus.o_out !== 8'h02) begin n_fail++; $display("FAIL rm_pre: got %h want 02", bus.o_out); end
    rst = 1'b1; bus.i_mode = 1'b0; bus.i_in = 3'd4; bus.i_in_valid = 1'b1; tick();
    n_checks++; if (bus.o_out !== 8'h00 || bus.o_idx !== 3'd0) begin
      n_fail++; $display("FAIL rm_out: out=%h idx=%0d want 00 0", bus.o_out, bus.o_idx);
    end
    n_checks++; if (bus.o_in_ready !== 1'b0 || bus.o_out_valid !== 1'b0 || bus.o_wrap !== 1'b0) begin
      n_fail++; $display("FAIL rm_ctl: ready=%b ov=%b wrap=%b want 0 0 0", bus.o_in_ready, bus.o_out_valid, bus.o_wrap);
    end
    bus.i_in_valid = 1'b0;
    rst = 1'b0; tick();
    n_checks++; if (bus.o_in_ready !== 1'b1 || bus.o_out !== 8'h00) begin
      n_fail++; $display("FAIL rm_after: ready=%b out=%h want 1 00", bus.o_in_ready, bus.o_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_direct();
    test_back_to_back();
    test_scan();
    test_disable_mid_scan();
    test_mode_switch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_3_8_scan.md
Name: decode_3_8_scan

Overview:
Registered 3-to-8 decoder, the inverse of the team's one-hot-to-binary encoders: a binary index in, a one-hot line select out. It has the same EN and HL output-polarity controls as those encoders. It adds two modes: direct mode, which decodes a handshaken index, and scan mode, which cycles the one-hot output through all lines at a programmable rate. Typical use is driving digit or row selects, for example multiplexed 7-segment anodes.

Parameters:
- N_SEL, default 3: index width; output width is 2^N_SEL (8 at default).
- DIV, default 4: clock cycles per scan step; legal range 1..65535.

Ports:
- CLK, input, 1: single clock; all state updates on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: block enable; 0 forces all lines inactive.
- HL, input, 1: output polarity; 1 = active-high lines, 0 = active-low (OUT inverted).
- MODE, input, 1: 0 = direct decode, 1 = auto scan.
- IN, input, N_SEL: index to decode (direct mode).
- IN_VALID, input, 1: IN is valid.
- IN_READY, output, 1: block accepts IN this cycle.
- OUT, output, 2^N_SEL: decoded select lines after polarity.
- IDX, output, N_SEL: index currently driven on OUT.
- OUT_VALID, output, 1: one-cycle pulse when a direct-mode decode reaches OUT.
- WRAP, output, 1: one-cycle pulse when scan steps from the last index to 0.

Behaviour:
- Internal registers:
  - raw: one-hot or zero, width 2^N_SEL.
  - IDX register.
  - state: S_OFF, S_DIRECT or S_SCAN.
  - prescaler cnt, 16 bits.
- OUT is combinational from raw: OUT = HL ? raw : ~raw. There is no registering on HL, and a change of HL takes effect the same cycle.
- Reset (RST=1 at edge):
  - state=S_OFF, raw=0, IDX=0, cnt=0, OUT_VALID=0, WRAP=0.
  - OUT therefore reads 0x00 if HL=1 and 0xFF if HL=0.
  - RST has priority over everything.
- Next state each edge: EN=0 -> S_OFF; EN=1 and MODE=0 -> S_DIRECT; EN=1 and MODE=1 -> S_SCAN.
- IN_READY = (state==S_DIRECT) && EN && !MODE, combinational.
- Entering S_OFF: raw<=0, IDX<=0, cnt<=0 on that edge. The block stays there while EN=0, and IN_VALID is ignored.
- S_DIRECT:
  - Transfer: IN_VALID && IN_READY at an edge -> raw<=1<<IN, IDX<=IN, OUT_VALID<=1 for exactly one cycle. Latency is 1 cycle from the accept edge.
  - Back-to-back transfers are allowed every cycle; OUT_VALID stays high continuously in that case.
  - With no transfer, raw and IDX hold and OUT_VALID<=0.
  - On entry from S_SCAN, raw and IDX keep their last scan value until the first transfer.
  - On entry from S_OFF, raw stays 0.
- S_SCAN:
  - On the entry edge, from any other state: IDX<=0, raw<=1, cnt<=0, WRAP<=0.
  - Each cycle after that: if cnt==DIV-1, then cnt<=0, IDX<=IDX+1 (mod 2^N_SEL), raw<=1<<(IDX+1); otherwise cnt<=cnt+1.
  - Each index is therefore held exactly DIV cycles.
  - WRAP<=1 for one cycle on the edge where IDX goes from 2^N_SEL-1 to 0, else 0.
  - DIV=1 steps every cycle.
  - IN_READY=0 and OUT_VALID=0 throughout scan mode.
- Simultaneous events:
  - If MODE or EN changes in the same cycle as IN_VALID, IN_READY is already low, so no transfer occurs.
  - A mode change restarts scan at index 0. cnt is not preserved across leaving S_SCAN.
- raw is always zero or exactly one-hot; no other value is legal (assertion in the bench).

Test Plan:
- Reset and polarity: assert RST for 2 cycles with HL=1 -> OUT=0x00, IDX=0, IN_READY=0. Toggle HL=0 while in reset -> OUT=0xFF in the same cycle.
- Direct decode: EN=1, MODE=0, HL=1; IN=5 with IN_VALID for 1 cycle -> next cycle OUT=0x20, IDX=5, one-cycle OUT_VALID pulse. Set HL=0 -> OUT=0xDF.
- Back-to-back handshake: IN=0,3,7 on three consecutive valid cycles -> OUT=0x01,0x08,0x80 on the next three cycles, with OUT_VALID high for all 3.
- Scan with DIV=4, HL=1: MODE=1 -> OUT=0x01 for 4 cycles, then 0x02, ... 0x80, then 0x01. WRAP is high exactly on the 0x80->0x01 edge, once per 32 cycles. IN_VALID is ignored throughout.
- Disable mid-scan: drop EN while OUT=0x10 -> next cycle OUT=0x00 (0xFF if HL=0). Re-raise EN with MODE=1 -> scan restarts at 0x01 with a full 4-cycle dwell.
- Mode switch and reset mid-operation: switch MODE 1->0 at OUT=0x04 -> OUT holds 0x04 and IN_READY=1 next cycle. Assert RST mid-scan -> OUT=0x00 next cycle and state S_OFF until EN/MODE are re-evaluated after reset.
